// File: rtl/buf_pkg.sv
// Shared definitions for the ping-pong buffer bank.
// Holds the error-flag bit positions, a generic bank-count type and the
// helpers that derive the bank-index and lane-select widths from the
// parameters.
package buf_pkg;

  localparam int ERR_OVF    = 0;  // commit while every bank is committed
  localparam int ERR_UDF    = 1;  // release while no bank is committed
  localparam int MAX_BANK_W = 8;

  typedef logic [MAX_BANK_W:0] bank_cnt_t;

  // Width of a bank index. This is never 0, even for a single bank.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Number of load-address bits that select the lane inside an exec word.
  function automatic int lane_bits(input int pack);
    return $clog2(pack);
  endfunction

endpackage

// File: rtl/buf_pp_mem.sv
// Banked simple-dual-port storage for buf_pp_bank.
// The storage is split into PACK lane memories so that one read returns
// PACK consecutive load words. Each lane memory is addressed by
// {bank, exec word address}. Writes are one load word wide. Reads are
// registered, with one cycle of latency. The array has no reset.
// Ports:
//   clk                                 clock
//   wr_en / wr_bank / wr_addr / wr_data narrow write port
//   rd_en / rd_bank / rd_addr           wide read request
//   rd_data                             registered PACK-word read data
module buf_pp_mem import buf_pkg::*; #(
  parameter int NUM_BANKS     = 2,
  parameter int LD_ADDR_WIDTH = 10,
  parameter int LD_DATA_WIDTH = 8,
  parameter int PACK          = 1,
  parameter int BANK_W        = bank_w(NUM_BANKS),
  parameter int EX_ADDR_WIDTH = LD_ADDR_WIDTH - lane_bits(PACK),
  parameter int EX_DATA_WIDTH = LD_DATA_WIDTH * PACK
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic [LD_ADDR_WIDTH-1:0] wr_addr,
  input  logic [LD_DATA_WIDTH-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [BANK_W-1:0]        rd_bank,
  input  logic [EX_ADDR_WIDTH-1:0] rd_addr,
  output logic [EX_DATA_WIDTH-1:0] rd_data
);

  localparam int LANE_BITS = lane_bits(PACK);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int ROW_W     = BANK_W + EX_ADDR_WIDTH;
  localparam int DEPTH     = 1 << ROW_W;

  logic [ROW_W-1:0]  wr_row;
  logic [ROW_W-1:0]  rd_row;
  logic [LANE_W-1:0] wr_lane;

  assign rd_row = {rd_bank, rd_addr};

  // With PACK=1 there are no lane bits, so the whole load address is the row.
  if (PACK == 1) begin : g_nolane
    assign wr_row  = {wr_bank, wr_addr};
    assign wr_lane = '0;
  end else begin : g_lane
    assign wr_row  = {wr_bank, wr_addr[LD_ADDR_WIDTH-1:LANE_BITS]};
    assign wr_lane = wr_addr[LANE_BITS-1:0];
  end

  for (genvar g = 0; g < PACK; g++) begin : g_lanes
    logic [LD_DATA_WIDTH-1:0] mem [DEPTH];
    logic [LD_DATA_WIDTH-1:0] q;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_lane == LANE_W'(g))) mem[wr_row] <= wr_data;
      if (rd_en) q <= mem[rd_row];
    end

    assign rd_data[g*LD_DATA_WIDTH +: LD_DATA_WIDTH] = q;
  end

endmodule

// File: rtl/buf_pp_bank.sv
// Multi-bank ping-pong buffer between the DMA load engine and the PE operand
// fetch. The load side fills the bank at wr_ptr and commits it. The exec
// side reads the bank at rd_ptr and releases it. cnt counts the banks that
// are committed and not yet released, and that count sets which side owns
// each bank.
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   ld_wr_en/ld_addr/ld_data/ld_commit       load-side strobes
//   ld_bank_rdy, ld_bank_idx                 load ownership status
//   ex_rd_en/ex_addr/ex_release              exec-side strobes
//   ex_bank_rdy, ex_bank_idx                 exec ownership status
//   ex_data, ex_data_vld                     read data, valid one cycle later
//   full_cnt                                 committed bank count
//   err_flags                                sticky [0] overflow, [1] underflow
//
// state        | meaning
// cnt == 0     | every bank is owned by load; exec is idle
// 0 < cnt < N  | both sides own at least one bank
// cnt == N     | every bank is committed; load is stalled
module buf_pp_bank import buf_pkg::*; #(
  parameter int NUM_BANKS     = 2,
  parameter int LD_ADDR_WIDTH = 10,
  parameter int LD_DATA_WIDTH = 8,
  parameter int PACK          = 1,
  parameter int EX_DATA_WIDTH = LD_DATA_WIDTH * PACK,
  parameter int EX_ADDR_WIDTH = LD_ADDR_WIDTH - lane_bits(PACK),
  parameter int BANK_W        = bank_w(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_wr_en,
  input  logic [LD_ADDR_WIDTH-1:0] ld_addr,
  input  logic [LD_DATA_WIDTH-1:0] ld_data,
  input  logic                     ld_commit,
  output logic                     ld_bank_rdy,
  output logic [BANK_W-1:0]        ld_bank_idx,
  input  logic                     ex_rd_en,
  input  logic [EX_ADDR_WIDTH-1:0] ex_addr,
  input  logic                     ex_release,
  output logic                     ex_bank_rdy,
  output logic [BANK_W-1:0]        ex_bank_idx,
  output logic [EX_DATA_WIDTH-1:0] ex_data,
  output logic                     ex_data_vld,
  output logic [BANK_W:0]          full_cnt,
  output logic [1:0]               err_flags
);

  logic [BANK_W-1:0]        wr_ptr, wr_ptr_nxt;
  logic [BANK_W-1:0]        rd_ptr, rd_ptr_nxt;
  logic [BANK_W:0]          cnt, cnt_nxt;
  logic [1:0]               err_q, err_nxt;
  logic                     vld_q;
  logic                     commit_ok, release_ok, wr_ok, rd_ok;
  logic [EX_DATA_WIDTH-1:0] mem_rd_data;

  assign ld_bank_rdy = (cnt < (BANK_W+1)'(NUM_BANKS));
  assign ex_bank_rdy = (cnt != '0);

  assign commit_ok  = ld_commit  & ld_bank_rdy;
  assign release_ok = ex_release & ex_bank_rdy;
  assign wr_ok      = ld_wr_en   & ld_bank_rdy;
  assign rd_ok      = ex_rd_en   & ex_bank_rdy;

  // NUM_BANKS is a power of two, so the pointers wrap on overflow.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    err_nxt    = err_q;
    if (commit_ok)  wr_ptr_nxt = wr_ptr + BANK_W'(1);
    if (release_ok) rd_ptr_nxt = rd_ptr + BANK_W'(1);
    case ({commit_ok, release_ok})
      2'b10:   cnt_nxt = cnt + (BANK_W+1)'(1);
      2'b01:   cnt_nxt = cnt - (BANK_W+1)'(1);
      default: cnt_nxt = cnt;
    endcase
    if (ld_commit  && !ld_bank_rdy) err_nxt[ERR_OVF] = 1'b1;
    if (ex_release && !ex_bank_rdy) err_nxt[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      err_q  <= err_nxt;
      vld_q  <= rd_ok;
    end
  end

  // Bank ownership guarantees that the bank being written is never the bank
  // being read, so the memory needs no collision handling.
  buf_pp_mem #(
    .NUM_BANKS     (NUM_BANKS),
    .LD_ADDR_WIDTH (LD_ADDR_WIDTH),
    .LD_DATA_WIDTH (LD_DATA_WIDTH),
    .PACK          (PACK),
    .BANK_W        (BANK_W),
    .EX_ADDR_WIDTH (EX_ADDR_WIDTH),
    .EX_DATA_WIDTH (EX_DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_bank (wr_ptr),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_ok),
    .rd_bank (rd_ptr),
    .rd_addr (ex_addr),
    .rd_data (mem_rd_data)
  );

  assign ld_bank_idx = wr_ptr;
  assign ex_bank_idx = rd_ptr;
  assign full_cnt    = cnt;
  assign err_flags   = err_q;
  assign ex_data_vld = vld_q;
  assign ex_data     = vld_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_buf_pp_bank.sv
module tb_buf_pp_bank;

  localparam int NB   = 2;
  localparam int LAW  = 6;
  localparam int LDW  = 8;
  localparam int PK   = 4;
  localparam int EXW  = LDW * PK;
  localparam int EAW  = LAW - 2;
  localparam int BW   = 1;
  localparam int NWRD = 1 << LAW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           ld_wr_en = 1'b0;
  logic [LAW-1:0] ld_addr = '0;
  logic [LDW-1:0] ld_data = '0;
  logic           ld_commit = 1'b0;
  logic           ld_bank_rdy;
  logic [BW-1:0]  ld_bank_idx;
  logic           ex_rd_en = 1'b0;
  logic [EAW-1:0] ex_addr = '0;
  logic           ex_release = 1'b0;
  logic           ex_bank_rdy;
  logic [BW-1:0]  ex_bank_idx;
  logic [EXW-1:0] ex_data;
  logic           ex_data_vld;
  logic [BW:0]    full_cnt;
  logic [1:0]     err_flags;

  buf_pp_bank #(
    .NUM_BANKS(NB), .LD_ADDR_WIDTH(LAW), .LD_DATA_WIDTH(LDW), .PACK(PK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_commit(ld_commit), .ld_bank_rdy(ld_bank_rdy), .ld_bank_idx(ld_bank_idx),
    .ex_rd_en(ex_rd_en), .ex_addr(ex_addr), .ex_release(ex_release),
    .ex_bank_rdy(ex_bank_rdy), .ex_bank_idx(ex_bank_idx),
    .ex_data(ex_data), .ex_data_vld(ex_data_vld),
    .full_cnt(full_cnt), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  // Reference model: committed banks form a FIFO of bank numbers
  // (oldest first), and the load side fills banks in round-robin order.
  logic [LDW-1:0] mdl_mem [NB][NWRD];
  int             exq[$];
  int             mdl_ld_bank = 0;
  logic [1:0]     mdl_err = '0;
  logic           mdl_vld = 1'b0;
  logic [EXW-1:0] mdl_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_state();
    int ex_b;
    ex_b = (exq.size() > 0) ? exq[0] : mdl_ld_bank;
    chk("ld_bank_rdy", 64'(ld_bank_rdy), 64'(exq.size() < NB));
    chk("ex_bank_rdy", 64'(ex_bank_rdy), 64'(exq.size() > 0));
    chk("ld_bank_idx", 64'(ld_bank_idx), 64'(mdl_ld_bank));
    chk("ex_bank_idx", 64'(ex_bank_idx), 64'(ex_b));
    chk("full_cnt",    64'(full_cnt),    64'(exq.size()));
    chk("err_flags",   64'(err_flags),   64'(mdl_err));
    chk("ex_data_vld", 64'(ex_data_vld), 64'(mdl_vld));
    chk("ex_data",     64'(ex_data),     64'(mdl_data));
  endtask

  // Check the state from the previous edge, drive one cycle of inputs at the
  // negedge, and advance the model to the state expected after the next posedge.
  task automatic step(input bit we, input int wa, input int wd, input bit cm,
                      input bit re, input int ra, input bit rl);
    int  occ;
    bit  c_ok, r_ok;
    @(negedge clk);
    check_state();
    ld_wr_en   = we;  ld_addr = LAW'(wa); ld_data = LDW'(wd);
    ld_commit  = cm;
    ex_rd_en   = re;  ex_addr = EAW'(ra);
    ex_release = rl;
    occ = exq.size();
    if (re && occ > 0) begin
      mdl_vld  = 1'b1;
      mdl_data = '0;
      for (int i = 0; i < PK; i++)
        mdl_data = mdl_data | (EXW'(mdl_mem[exq[0]][ra*PK + i]) << (LDW*i));
    end else begin
      mdl_vld  = 1'b0;
      mdl_data = '0;
    end
    if (we && occ < NB) mdl_mem[mdl_ld_bank][wa] = LDW'(wd);
    c_ok = cm && (occ < NB);
    r_ok = rl && (occ > 0);
    if (cm && !c_ok) mdl_err[0] = 1'b1;
    if (rl && !r_ok) mdl_err[1] = 1'b1;
    if (r_ok) void'(exq.pop_front());
    if (c_ok) begin
      exq.push_back(mdl_ld_bank);
      mdl_ld_bank = (mdl_ld_bank + 1) % NB;
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted in the middle of the first cycle.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ld_rdy", 64'(ld_bank_rdy), 64'd1);
    chk("rst_ex_rdy", 64'(ex_bank_rdy), 64'd0);
    chk("rst_ld_idx", 64'(ld_bank_idx), 64'd0);
    chk("rst_cnt",    64'(full_cnt),    64'd0);
    chk("rst_vld",    64'(ex_data_vld), 64'd0);
    chk("rst_data",   64'(ex_data),     64'd0);
    chk("rst_err",    64'(err_flags),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word of both banks so that any later read has a known value.
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < NWRD; a++) step(1, a, int'($urandom_range(0, 255)), 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // PACK=4 lane order.
    for (int i = 0; i < 4; i++) step(1, 4 + i, 8'hA0 + i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    peek();
    chk("pack4_data", 64'(ex_data), 64'h00000000A3A2A1A0);
    chk("pack4_vld",  64'(ex_data_vld), 64'd1);
    chk("pack4_cnt",  64'(full_cnt), 64'd1);
    chk("pack4_ldix", 64'(ld_bank_idx), 64'd1);
    chk("pack4_exix", 64'(ex_bank_idx), 64'd0);

    // Overflow: fill both banks, commit once more, then write while full.
    step(0, 0, 0, 1, 0, 0, 0);
    peek();
    chk("full_ld_rdy", 64'(ld_bank_rdy), 64'd0);
    step(0, 0, 0, 1, 0, 0, 0);
    peek();
    chk("ovf_err", 64'(err_flags), 64'b01);
    chk("ovf_cnt", 64'(full_cnt), 64'd2);
    step(1, 4, 8'hFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    peek();
    chk("drop_write", 64'(ex_data), 64'h00000000A3A2A1A0);

    // Commit and release in the same cycle, then a release with nothing committed.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    peek();
    chk("simul_cnt",  64'(full_cnt), 64'd1);
    chk("simul_ldix", 64'(ld_bank_idx), 64'd1);
    chk("simul_exix", 64'(ex_bank_idx), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    peek();
    chk("udf_err", 64'(err_flags), 64'b11);

    // Reset in the cycle after an accepted read.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    peek();
    chk("pre_rst_vld", 64'(ex_data_vld), 64'd1);
    rst_n = 1'b0;
    ld_wr_en = 0; ld_commit = 0; ex_rd_en = 0; ex_release = 0;
    #1;
    chk("mid_rst_vld",  64'(ex_data_vld), 64'd0);
    chk("mid_rst_data", 64'(ex_data), 64'd0);
    chk("mid_rst_cnt",  64'(full_cnt), 64'd0);
    chk("mid_rst_err",  64'(err_flags), 64'd0);
    exq.delete();
    mdl_ld_bank = 0;
    mdl_err     = '0;
    mdl_vld     = 1'b0;
    mdl_data    = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, NWRD-1)),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, (1 << EAW) - 1)),
           ($urandom_range(0, 5) == 0));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
